pic_exec_ctrl: RTL and testbench

Instruction-cycle sequencer and decoder for the PIC16C5x core. It holds the current 12-bit instruction and runs a four-phase Q1–Q4 cycle. It drives the ALU's function code, bit-select and literal, then writes the ALU result (or a bypass value) back to W or the file register. It also owns skip and flush handling and the program-counter controls, so it is the control end of the ALU interface.

---
 rtl/pic_exec_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_pic_exec_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pic_exec_ctrl.sv
// PIC16C5x instruction-cycle sequencer and decoder.
// Runs the Q1-Q4 cycle, drives the ALU and issues write-back and PC strobes.
package pic_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ALU_FUNC_WIDTH = 4;
  localparam int BIT_SEL_WIDTH = 3;

  typedef enum logic [ALU_FUNC_WIDTH-1:0] {
    ALU_ADDWF, ALU_SUBWF, ALU_ANDWF, ALU_IORWF,
    ALU_XORWF, ALU_COMF, ALU_INCF, ALU_DECF,
    ALU_RRF, ALU_RLF, ALU_SWAPF, ALU_BCF,
    ALU_BSF, ALU_IORLW, ALU_ANDLW, ALU_IDLE
  } aluFunc_t;

  typedef enum logic [2:0] {
    WB_ALU, WB_W, WB_F, WB_ZERO, WB_LIT, WB_XORL
  } wbSel_t;

  typedef enum logic [1:0] {Q1, Q2, Q3, Q4} qPhase_t;

  typedef struct packed {
    aluFunc_t aluFunc;
    wbSel_t   wbSel;
    logic     wDest;
    logic     fDest;
    logic     zUpd;
    logic     skipZ;
    logic     skipClr;
    logic     skipSet;
    logic     isGoto;
    logic     isCall;
    logic     isRet;
  } dec_t;

  localparam dec_t DEC_NOP = '{
    ALU_IDLE, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0
  };
endpackage

module pic_exec_ctrl
  import pic_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [11:0]               instIn,
  input  logic [DATA_WIDTH-1:0]     wIn,
  input  logic [DATA_WIDTH-1:0]     fIn,
  input  logic [DATA_WIDTH-1:0]     aluResultIn,
  output logic [ALU_FUNC_WIDTH-1:0] aluFuncOut,
  output logic [BIT_SEL_WIDTH-1:0]  bitSelOut,
  output logic [7:0]                litOut,
  output logic [4:0]                fAddrOut,
  output logic [DATA_WIDTH-1:0]     wbDataOut,
  output logic                      wWrEn,
  output logic                      fWrEn,
  output logic                      zWrEn,
  output logic                      zOut,
  output logic [1:0]                qPhaseOut,
  output logic                      pcIncOut,
  output logic                      pcLoadOut,
  output logic                      pcSrcOut,
  output logic [8:0]                pcLoadVal,
  output logic                      pushOut,
  output logic                      popOut
);

  qPhase_t q, qNext;
  dec_t dec, decNext;
  logic [8:0] irArg;
  logic [11:0] instNext;
  logic flush, flushPend;
  logic [7:0] wbData;
  logic skip, branch, d;

  always_ff @(posedge clk) begin
    if (!rst_n) q <= Q1;
    else q <= qNext;
  end

  always_comb begin
    qNext = q;
    unique case (q)
      Q1: qNext = Q2;
      Q2: qNext = Q3;
      Q3: qNext = Q4;
      Q4: qNext = Q1;
      default: qNext = Q1;
    endcase
  end

  // A pending skip/branch replaces the fetched word with NOP.
  assign instNext = flushPend ? 12'h000 : instIn;
  assign d = instNext[5];

  always_comb begin
    decNext = DEC_NOP;
    unique case (1'b1)
      instNext[11:5] == 7'b0000001: begin
        decNext.fDest = 1'b1;
        decNext.wbSel = WB_W;
      end
      instNext == 12'h040: begin
        decNext.wDest = 1'b1;
        decNext.wbSel = WB_ZERO;
        decNext.zUpd = 1'b1;
      end
      instNext[11:5] == 7'b0000011: begin
        decNext.fDest = 1'b1;
        decNext.wbSel = WB_ZERO;
        decNext.zUpd = 1'b1;
      end
      instNext[11:10] == 2'b00 && instNext[9:7] != 3'b000: begin
        decNext.wDest = ~d;
        decNext.fDest = d;
        decNext.zUpd = 1'b1;
        case (instNext[9:6])
          4'b0010: decNext.aluFunc = ALU_SUBWF;
          4'b0011: decNext.aluFunc = ALU_DECF;
          4'b0100: decNext.aluFunc = ALU_IORWF;
          4'b0101: decNext.aluFunc = ALU_ANDWF;
          4'b0110: decNext.aluFunc = ALU_XORWF;
          4'b0111: decNext.aluFunc = ALU_ADDWF;
          4'b1000: decNext.wbSel = WB_F;
          4'b1001: decNext.aluFunc = ALU_COMF;
          4'b1010: decNext.aluFunc = ALU_INCF;
          4'b1011: begin
            decNext.aluFunc = ALU_DECF;
            decNext.zUpd = 1'b0;
            decNext.skipZ = 1'b1;
          end
          4'b1100: begin
            decNext.aluFunc = ALU_RRF;
            decNext.zUpd = 1'b0;
          end
          4'b1101: begin
            decNext.aluFunc = ALU_RLF;
            decNext.zUpd = 1'b0;
          end
          4'b1110: begin
            decNext.aluFunc = ALU_SWAPF;
            decNext.zUpd = 1'b0;
          end
          default: begin
            decNext.aluFunc = ALU_INCF;
            decNext.zUpd = 1'b0;
            decNext.skipZ = 1'b1;
          end
        endcase
      end
      instNext[11:10] == 2'b01: begin
        case (instNext[9:8])
          2'b00: begin
            decNext.aluFunc = ALU_BCF;
            decNext.fDest = 1'b1;
          end
          2'b01: begin
            decNext.aluFunc = ALU_BSF;
            decNext.fDest = 1'b1;
          end
          2'b10: decNext.skipClr = 1'b1;
          default: decNext.skipSet = 1'b1;
        endcase
      end
      instNext[11:8] == 4'h8: begin
        decNext.isRet = 1'b1;
        decNext.wDest = 1'b1;
        decNext.wbSel = WB_LIT;
      end
      instNext[11:8] == 4'h9: decNext.isCall = 1'b1;
      instNext[11:9] == 3'b101: decNext.isGoto = 1'b1;
      instNext[11:8] == 4'hC: begin
        decNext.wDest = 1'b1;
        decNext.wbSel = WB_LIT;
      end
      instNext[11:8] == 4'hD: begin
        decNext.aluFunc = ALU_IORLW;
        decNext.wDest = 1'b1;
        decNext.zUpd = 1'b1;
      end
      instNext[11:8] == 4'hE: begin
        decNext.aluFunc = ALU_ANDLW;
        decNext.wDest = 1'b1;
        decNext.zUpd = 1'b1;
      end
      instNext[11:8] == 4'hF: begin
        decNext.wDest = 1'b1;
        decNext.wbSel = WB_XORL;
        decNext.zUpd = 1'b1;
      end
      default: decNext = DEC_NOP;
    endcase
  end

  always_comb begin
    wbData = aluResultIn;
    unique case (dec.wbSel)
      WB_W:    wbData = wIn;
      WB_F:    wbData = fIn;
      WB_ZERO: wbData = 8'h00;
      WB_LIT:  wbData = irArg[7:0];
      WB_XORL: wbData = irArg[7:0] ^ wIn;
      default: wbData = aluResultIn;
    endcase
  end

  assign skip = ~flush & (
    (dec.skipZ & (aluResultIn == 8'h00)) |
    (dec.skipClr & ~fIn[irArg[7:5]]) |
    (dec.skipSet & fIn[irArg[7:5]]));
  assign branch = ~flush & (dec.isGoto | dec.isCall | dec.isRet);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec <= DEC_NOP;
      irArg <= '0;
      flush <= 1'b0;
      flushPend <= 1'b0;
      wbDataOut <= '0;
      zOut <= 1'b0;
      {wWrEn, fWrEn, zWrEn} <= '0;
      {pcIncOut, pcLoadOut, pushOut, popOut} <= '0;
    end else begin
      {wWrEn, fWrEn, zWrEn} <= '0;
      {pcIncOut, pcLoadOut, pushOut, popOut} <= '0;
      if (q == Q3) begin
        wbDataOut <= wbData;
        zOut <= (wbData == 8'h00);
        flushPend <= skip | branch;
        wWrEn <= dec.wDest & ~flush;
        fWrEn <= dec.fDest & ~flush;
        zWrEn <= dec.zUpd & ~flush;
        pcLoadOut <= branch;
        pcIncOut <= ~branch;
        pushOut <= dec.isCall & ~flush;
        popOut <= dec.isRet & ~flush;
      end
      if (q == Q4) begin
        dec <= decNext;
        irArg <= instNext[8:0];
        flush <= flushPend;
        flushPend <= 1'b0;
      end
    end
  end

  assign qPhaseOut = q;
  assign aluFuncOut = dec.aluFunc;
  assign bitSelOut = irArg[7:5];
  assign litOut = irArg[7:0];
  assign fAddrOut = irArg[4:0];
  assign pcSrcOut = dec.isRet;

  always_comb begin
    pcLoadVal = 9'h000;
    unique case (1'b1)
      dec.isGoto: pcLoadVal = irArg;
      dec.isCall: pcLoadVal = {1'b0, irArg[7:0]};
      default:    pcLoadVal = 9'h000;
    endcase
  end

endmodule

// File: tb/tb_pic_exec_ctrl.sv
// Scoreboard bench for pic_exec_ctrl: expected Q4 results queued per cycle.
// Q1-Q3 strobe silence and mid-cycle reset are also checked.
module tb_pic_exec_ctrl;
  import pic_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] instIn = 12'h000;
  logic [7:0] wIn = 8'h00;
  logic [7:0] fIn = 8'h00;
  logic [7:0] aluResultIn = 8'h00;
  logic [3:0] aluFuncOut;
  logic [2:0] bitSelOut;
  logic [7:0] litOut;
  logic [4:0] fAddrOut;
  logic [7:0] wbDataOut;
  logic wWrEn, fWrEn, zWrEn, zOut;
  logic [1:0] qPhaseOut;
  logic pcIncOut, pcLoadOut, pcSrcOut;
  logic [8:0] pcLoadVal;
  logic pushOut, popOut;

  pic_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instIn(instIn),
    .wIn(wIn), .fIn(fIn), .aluResultIn(aluResultIn),
    .aluFuncOut(aluFuncOut), .bitSelOut(bitSelOut),
    .litOut(litOut), .fAddrOut(fAddrOut),
    .wbDataOut(wbDataOut), .wWrEn(wWrEn), .fWrEn(fWrEn),
    .zWrEn(zWrEn), .zOut(zOut), .qPhaseOut(qPhaseOut),
    .pcIncOut(pcIncOut), .pcLoadOut(pcLoadOut),
    .pcSrcOut(pcSrcOut), .pcLoadVal(pcLoadVal),
    .pushOut(pushOut), .popOut(popOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] s;
    logic src;
    int wb;
    logic [8:0] lv;
    logic [3:0] alu;
    logic [4:0] fa;
  } exp_t;

  exp_t sb[$];
  int nCmp = 0;
  int nErr = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // s = {wWr,fWr,zWr,inc,load,push,pop}; wb < 0 leaves wb/z unchecked
  function automatic exp_t mk(input logic [6:0] s, input logic src,
                              input int wb, input logic [8:0] lv,
                              input aluFunc_t alu, input logic [4:0] fa);
    exp_t e;
    e.s = s; e.src = src; e.wb = wb;
    e.lv = lv; e.alu = alu; e.fa = fa;
    return e;
  endfunction

  function automatic exp_t nopE();
    return mk(7'b0001000, 1'b0, -1, 9'h000, ALU_IDLE, 5'd0);
  endfunction

  task automatic runCycle(input logic [11:0] nxt, input logic [7:0] w,
                          input logic [7:0] f, input logic [7:0] a,
                          input exp_t e);
    sb.push_back(e);
    instIn = nxt; wIn = w; fIn = f; aluResultIn = a;
    repeat (4) @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  logic monOn = 1'b0;
  always @(negedge clk) begin
    if (monOn) begin
      if (qPhaseOut == 2'd3) begin
        if (sb.size() == 0) begin
          check("sbEmpty", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobes", 32'({wWrEn, fWrEn, zWrEn, pcIncOut,
                pcLoadOut, pushOut, popOut}), 32'(e.s));
          check("aluFunc", 32'(aluFuncOut), 32'(e.alu));
          check("fAddr", 32'(fAddrOut), 32'(e.fa));
          check("pcLoadVal", 32'(pcLoadVal), 32'(e.lv));
          check("pcSrc", 32'(pcSrcOut), 32'(e.src));
          if (e.wb >= 0) begin
            check("wbData", 32'(wbDataOut), 32'(e.wb));
            check("zOut", 32'(zOut), 32'(e.wb == 0));
          end
        end
      end else begin
        check("quiet", 32'({wWrEn, fWrEn, zWrEn, pcIncOut,
              pcLoadOut, pushOut, popOut}), 32'(0));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstQ", 32'(qPhaseOut), 32'(0));
    check("rstAlu", 32'(aluFuncOut), 32'(ALU_IDLE));
    check("rstWb", 32'(wbDataOut), 32'(0));
    check("rstStrb", 32'({wWrEn, fWrEn, zWrEn, zOut, pcIncOut,
          pcLoadOut, pushOut, popOut, pcSrcOut}), 32'(0));
    check("rstLit", 32'({litOut, pcLoadVal}), 32'(0));
    rst_n = 1'b1;
    monOn = 1'b1;

    runCycle(12'h1E3, 8'h00, 8'h00, 8'h00, nopE());
    runCycle(12'hC00, 8'h05, 8'h0A, 8'h0F,
             mk(7'b0111000, 1'b0, 8'h0F, 9'h000, ALU_ADDWF, 5'd3));
    runCycle(12'hFFF, 8'h11, 8'h22, 8'h33,
             mk(7'b1001000, 1'b0, 8'h00, 9'h000, ALU_IDLE, 5'd0));
    runCycle(12'h2E5, 8'h0F, 8'h00, 8'h55,
             mk(7'b1011000, 1'b0, 8'hF0, 9'h000, ALU_IDLE, 5'h1F));
    runCycle(12'h1E3, 8'h00, 8'h01, 8'h00,
             mk(7'b0101000, 1'b0, 8'h00, 9'h000, ALU_DECF, 5'd5));
    runCycle(12'h2E5, 8'h00, 8'h00, 8'h00, nopE());
    runCycle(12'h1E3, 8'h00, 8'h02, 8'h01,
             mk(7'b0101000, 1'b0, 8'h01, 9'h000, ALU_DECF, 5'd5));
    runCycle(12'hBA5, 8'h80, 8'h80, 8'h00,
             mk(7'b0111000, 1'b0, 8'h00, 9'h000, ALU_ADDWF, 5'd3));
    runCycle(12'hA12, 8'h00, 8'h00, 8'h00,
             mk(7'b0000100, 1'b0, -1, 9'h1A5, ALU_IDLE, 5'd5));
    runCycle(12'h940, 8'h00, 8'h00, 8'h00, nopE());
    runCycle(12'h877, 8'h00, 8'h00, 8'h00,
             mk(7'b0000110, 1'b0, -1, 9'h040, ALU_IDLE, 5'd0));
    runCycle(12'h833, 8'h00, 8'h00, 8'h00, nopE());
    runCycle(12'h000, 8'h00, 8'h00, 8'h99,
             mk(7'b1000101, 1'b1, 8'h33, 9'h000, ALU_IDLE, 5'h13));
    runCycle(12'h647, 8'h00, 8'h00, 8'h00, nopE());
    runCycle(12'h747, 8'h00, 8'h04, 8'h00,
             mk(7'b0001000, 1'b0, -1, 9'h000, ALU_IDLE, 5'd7));
    runCycle(12'h029, 8'h00, 8'h04, 8'h00,
             mk(7'b0001000, 1'b0, -1, 9'h000, ALU_IDLE, 5'd7));
    runCycle(12'h029, 8'hA5, 8'h00, 8'h00, nopE());
    runCycle(12'h040, 8'hA5, 8'h00, 8'h00,
             mk(7'b0101000, 1'b0, 8'hA5, 9'h000, ALU_IDLE, 5'd9));
    runCycle(12'h084, 8'h77, 8'h66, 8'h55,
             mk(7'b1011000, 1'b0, 8'h00, 9'h000, ALU_IDLE, 5'd0));
    runCycle(12'h1E3, 8'h10, 8'h20, 8'h3C,
             mk(7'b1011000, 1'b0, 8'h3C, 9'h000, ALU_SUBWF, 5'd4));

    instIn = 12'h000; wIn = 8'h01; fIn = 8'h02; aluResultIn = 8'h03;
    check("midFAddr", 32'(fAddrOut), 32'(3));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midQ3", 32'(qPhaseOut), 32'(2));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abortFWr", 32'(fWrEn), 32'(0));
    check("abortQ", 32'(qPhaseOut), 32'(0));
    check("abortIr", 32'({litOut, fAddrOut}), 32'(0));
    check("abortAlu", 32'(aluFuncOut), 32'(ALU_IDLE));
    rst_n = 1'b1;

    runCycle(12'h000, 8'h00, 8'h00, 8'h00, nopE());
    runCycle(12'h000, 8'h00, 8'h00, 8'h00, nopE());
    check("sbDrain", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
